// File: rtl/byte_striping_nlane_if.sv
// Striper bus: input word stream with flush/resync controls, and the
// registered lane outputs.
//   data_in    word to stripe           valid_in   data_in is a valid word
//   flush      emit a partial group     resync     drop partial group, pointer to 0
//   lane_out   lane k at [k*DATA_W +: DATA_W]
//   valid_out  per-lane new-data strobe
//   lane_ptr   next lane to receive     group_done full group completed
interface byte_striping_nlane_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4
);
    localparam int unsigned PTR_W = $clog2(LANES);

    logic [DATA_W-1:0]       data_in;
    logic                    valid_in;
    logic                    flush;
    logic                    resync;
    logic [LANES*DATA_W-1:0] lane_out;
    logic [LANES-1:0]        valid_out;
    logic [PTR_W-1:0]        lane_ptr;
    logic                    group_done;

    modport master (
        output data_in, valid_in, flush, resync,
        input  lane_out, valid_out, lane_ptr, group_done
    );

    modport slave (
        input  data_in, valid_in, flush, resync,
        output lane_out, valid_out, lane_ptr, group_done
    );
endinterface

// File: rtl/byte_striping_nlane.sv
// Round-robin byte striper: distributes DATA_W-bit words across LANES lanes.
// ALIGN=0 writes each accepted word straight to its lane; ALIGN=1 stages a
// lane group and presents it in one cycle, with flush/resync for partials.
//   clk_2f  single clock, rising edge
//   reset   asynchronous, active-high
//   bus     byte_striping_nlane_if slave (stream in, lanes out)
module byte_striping_nlane #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ALIGN  = 0
) (
    input  logic                 clk_2f,
    input  logic                 reset,
    byte_striping_nlane_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(LANES);

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } state_t;

    logic [LANES-1:0][DATA_W-1:0] lane_q;
    logic [LANES-1:0]             valid_q;
    logic [PTR_W-1:0]             ptr_q;
    logic                         done_q;

    logic                         accept_c;
    logic [PTR_W-1:0]             ptr_inc_c;

    // resync beats valid_in; pointer wraps naturally (LANES is a power of two)
    assign accept_c  = bus.valid_in & ~bus.resync;
    assign ptr_inc_c = ptr_q + PTR_W'(1);

    assign bus.lane_out   = lane_q;
    assign bus.valid_out  = valid_q;
    assign bus.lane_ptr   = ptr_q;
    assign bus.group_done = done_q;

    if (ALIGN == 0) begin : g_direct
        // Immediate mode: each accepted word lands on lane ptr_q next cycle
        always_ff @(posedge clk_2f or posedge reset) begin
            if (reset) begin
                lane_q  <= '0;
                valid_q <= '0;
                ptr_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                valid_q <= '0;
                done_q  <= 1'b0;
                if (bus.resync) begin
                    ptr_q <= '0;
                end else if (accept_c) begin
                    lane_q[ptr_q]  <= bus.data_in;
                    valid_q[ptr_q] <= 1'b1;
                    ptr_q          <= ptr_inc_c;
                end
            end
        end
    end else begin : g_aligned
        state_t                       state_q;
        logic [LANES-1:0][DATA_W-1:0] stage_q;
        logic [LANES-1:0]             fill_q;

        logic [LANES-1:0]             ptr_oh_c;
        logic [LANES-1:0]             fill_nx_c;
        logic [LANES-1:0][DATA_W-1:0] stage_nx_c;
        logic                         last_c;

        // Staging view including this cycle's word, so flush/complete see it
        always_comb begin
            ptr_oh_c        = '0;
            ptr_oh_c[ptr_q] = 1'b1;
            fill_nx_c       = fill_q | (accept_c ? ptr_oh_c : '0);
            stage_nx_c      = stage_q;
            if (accept_c) begin
                stage_nx_c[ptr_q] = bus.data_in;
            end
            last_c = accept_c && (ptr_q == PTR_W'(LANES - 1));
        end

        // Group FSM: EMPTY while nothing is staged, FILLING otherwise
        always_ff @(posedge clk_2f or posedge reset) begin
            if (reset) begin
                state_q <= EMPTY;
                stage_q <= '0;
                fill_q  <= '0;
                lane_q  <= '0;
                valid_q <= '0;
                ptr_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                valid_q <= '0;
                done_q  <= 1'b0;
                if (bus.resync) begin
                    ptr_q   <= '0;
                    fill_q  <= '0;
                    state_q <= EMPTY;
                end else begin
                    stage_q <= stage_nx_c;
                    if (accept_c) begin
                        ptr_q <= ptr_inc_c;
                    end
                    if (last_c) begin
                        // A flush on the completing word is just a completion
                        lane_q  <= stage_nx_c;
                        valid_q <= '1;
                        done_q  <= 1'b1;
                        fill_q  <= '0;
                        state_q <= EMPTY;
                    end else if (bus.flush && (state_q == FILLING || accept_c)) begin
                        for (int k = 0; k < int'(LANES); k++) begin
                            lane_q[k] <= fill_nx_c[k] ? stage_nx_c[k] : '0;
                        end
                        valid_q <= fill_nx_c;
                        done_q  <= &fill_nx_c;
                        ptr_q   <= '0;
                        fill_q  <= '0;
                        state_q <= EMPTY;
                    end else begin
                        fill_q <= fill_nx_c;
                        if (accept_c) begin
                            state_q <= FILLING;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_byte_striping_nlane.sv
module tb_byte_striping_nlane;
    localparam int unsigned DW = 32;

    logic clk_2f = 1'b0;
    logic reset;

    always #5 clk_2f = ~clk_2f;

    byte_striping_nlane_if #(.DATA_W(DW), .LANES(4)) if0 ();
    byte_striping_nlane_if #(.DATA_W(DW), .LANES(4)) if1 ();
    byte_striping_nlane_if #(.DATA_W(DW), .LANES(8)) if2 ();

    byte_striping_nlane #(.DATA_W(DW), .LANES(4), .ALIGN(0)) dut0 (.clk_2f(clk_2f), .reset(reset), .bus(if0));
    byte_striping_nlane #(.DATA_W(DW), .LANES(4), .ALIGN(1)) dut1 (.clk_2f(clk_2f), .reset(reset), .bus(if1));
    byte_striping_nlane #(.DATA_W(DW), .LANES(8), .ALIGN(1)) dut2 (.clk_2f(clk_2f), .reset(reset), .bus(if2));

    int n_vec = 0;
    int n_bad = 0;

    // reference model: per DUT, word counter, staged words and visible lanes
    int          m_l[3]  = '{4, 4, 8};
    bit          m_al[3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] m_out[3][8];
    logic [31:0] m_stg[3][8];
    bit          m_fill[3][8];
    int          m_cnt[3];
    logic [7:0]  m_vout[3];
    bit          m_gd[3];

    logic [255:0] a_lane[3];
    logic [7:0]   a_vout[3];
    logic [3:0]   a_ptr[3];
    logic         a_gd[3];

    typedef struct {
        bit           v, f, r;
        logic [31:0]  d;
        logic [3:0]   ev0;
        int           ep0;
        logic [3:0]   ev1;
        int           ep1;
        bit           egd1;
        bit           cl0;
        logic [127:0] el0;
        bit           cl1;
        logic [127:0] el1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, bit f, bit r, logic [31:0] d,
                                logic [3:0] ev0, int ep0, logic [3:0] ev1, int ep1, bit egd1,
                                bit cl0, logic [127:0] el0, bit cl1, logic [127:0] el1);
        vec_t t;
        t.v = v; t.f = f; t.r = r; t.d = d;
        t.ev0 = ev0; t.ep0 = ep0; t.ev1 = ev1; t.ep1 = ep1; t.egd1 = egd1;
        t.cl0 = cl0; t.el0 = el0; t.cl1 = cl1; t.el1 = el1;
        return t;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0; m_vout[d] = '0; m_gd[d] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                m_out[d][k] = '0; m_stg[d][k] = '0; m_fill[d][k] = 1'b0;
            end
        end
    endtask

    task automatic m_step(int d, bit v, bit f, bit r, logic [31:0] data);
        bit done;
        int nf;
        m_vout[d] = '0;
        m_gd[d]   = 1'b0;
        done      = 1'b0;
        if (r) begin
            m_cnt[d] = 0;
            for (int k = 0; k < 8; k++) m_fill[d][k] = 1'b0;
        end else begin
            if (v) begin
                if (!m_al[d]) begin
                    m_out[d][m_cnt[d]]  = data;
                    m_vout[d][m_cnt[d]] = 1'b1;
                end else begin
                    m_stg[d][m_cnt[d]]  = data;
                    m_fill[d][m_cnt[d]] = 1'b1;
                    if (m_cnt[d] == m_l[d] - 1) begin
                        for (int k = 0; k < m_l[d]; k++) begin
                            m_out[d][k]  = m_stg[d][k];
                            m_vout[d][k] = 1'b1;
                            m_fill[d][k] = 1'b0;
                        end
                        m_gd[d] = 1'b1;
                        done    = 1'b1;
                    end
                end
                m_cnt[d] = (m_cnt[d] + 1) % m_l[d];
            end
            nf = 0;
            for (int k = 0; k < m_l[d]; k++) nf += int'(m_fill[d][k]);
            if (m_al[d] && f && !done && nf > 0) begin
                for (int k = 0; k < m_l[d]; k++) begin
                    m_out[d][k]  = m_fill[d][k] ? m_stg[d][k] : 32'h0;
                    m_vout[d][k] = m_fill[d][k];
                    m_fill[d][k] = 1'b0;
                end
                m_gd[d]  = (nf == m_l[d]);
                m_cnt[d] = 0;
            end
        end
    endtask

    function automatic logic [255:0] m_lanes(int d);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < m_l[d]; k++) r[k*32 +: 32] = m_out[d][k];
        return r;
    endfunction

    task automatic snap();
        a_lane[0] = 256'(if0.lane_out); a_vout[0] = 8'(if0.valid_out);
        a_ptr[0]  = 4'(if0.lane_ptr);   a_gd[0]   = if0.group_done;
        a_lane[1] = 256'(if1.lane_out); a_vout[1] = 8'(if1.valid_out);
        a_ptr[1]  = 4'(if1.lane_ptr);   a_gd[1]   = if1.group_done;
        a_lane[2] = 256'(if2.lane_out); a_vout[2] = 8'(if2.valid_out);
        a_ptr[2]  = 4'(if2.lane_ptr);   a_gd[2]   = if2.group_done;
    endtask

    task automatic chk(string nm, int d, logic [255:0] act, logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        for (int d = 0; d < 3; d++) begin
            chk("lane_out", d, a_lane[d], m_lanes(d));
            chk("valid_out", d, 256'(a_vout[d]), 256'(m_vout[d]));
            chk("lane_ptr", d, 256'(a_ptr[d]), 256'(m_cnt[d]));
            chk("group_done", d, 256'(a_gd[d]), 256'(m_gd[d]));
        end
    endtask

    task automatic set_in(bit v, bit f, bit r, logic [31:0] d);
        if0.valid_in = v; if0.flush = f; if0.resync = r; if0.data_in = d;
        if1.valid_in = v; if1.flush = f; if1.resync = r; if1.data_in = d;
        if2.valid_in = v; if2.flush = f; if2.resync = r; if2.data_in = d;
    endtask

    task automatic drive(bit v, bit f, bit r, logic [31:0] d);
        set_in(v, f, r, d);
        @(posedge clk_2f);
        #1;
        for (int k = 0; k < 3; k++) m_step(k, v, f, r, d);
        snap();
        chk_model();
    endtask

    initial begin
        vec_t t;
        logic [31:0] w;

        // ---- reset state ----
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk_2f);
        #1;
        reset = 1'b0;
        m_reset();
        snap();
        chk_model();

        // ---- directed table ----
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1, 0, 0, 32'hA0 + 32'(i),
                4'(1 << (i % 4)), (i + 1) % 4, (i % 4 == 3) ? 4'hF : 4'h0, (i + 1) % 4, (i % 4 == 3),
                (i == 7), {32'hA7, 32'hA6, 32'hA5, 32'hA4},
                (i == 3), {32'hA3, 32'hA2, 32'hA1, 32'hA0}));
        end
        tbl.push_back(mk(1, 0, 0, 32'h11,   4'b0001, 1, 4'h0, 1, 0, 0, '0, 0, '0));
        tbl.push_back(mk(0, 0, 0, 32'hDEAD, 4'b0000, 1, 4'h0, 1, 0, 0, '0, 0, '0));
        tbl.push_back(mk(0, 0, 0, 32'hBEEF, 4'b0000, 1, 4'h0, 1, 0, 0, '0, 0, '0));
        tbl.push_back(mk(1, 0, 0, 32'h22,   4'b0010, 2, 4'h0, 2, 0, 0, '0, 0, '0));
        tbl.push_back(mk(1, 0, 0, 32'h33,   4'b0100, 3, 4'h0, 3, 0,
                         1, {32'hA7, 32'h33, 32'h22, 32'h11}, 0, '0));
        tbl.push_back(mk(1, 0, 1, 32'h99,   4'b0000, 0, 4'h0, 0, 0,
                         1, {32'hA7, 32'h33, 32'h22, 32'h11}, 0, '0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, 0, 0, 32'(i + 1),
                4'(1 << i), (i + 1) % 4, (i == 3) ? 4'hF : 4'h0, (i + 1) % 4, (i == 3),
                0, '0, (i == 3), {32'h4, 32'h3, 32'h2, 32'h1}));
        end
        tbl.push_back(mk(1, 0, 0, 32'h5, 4'b0001, 1, 4'h0, 1, 0, 0, '0, 0, '0));
        tbl.push_back(mk(1, 0, 0, 32'h6, 4'b0010, 2, 4'h0, 2, 0, 0, '0, 0, '0));
        tbl.push_back(mk(1, 1, 0, 32'h7, 4'b0100, 3, 4'b0111, 0, 0,
                         0, '0, 1, {32'h0, 32'h7, 32'h6, 32'h5}));
        tbl.push_back(mk(0, 1, 0, 32'h0, 4'b0000, 3, 4'h0, 0, 0,
                         0, '0, 1, {32'h0, 32'h7, 32'h6, 32'h5}));
        tbl.push_back(mk(1, 0, 0, 32'h8, 4'b1000, 0, 4'h0, 1, 0, 0, '0, 0, '0));
        tbl.push_back(mk(1, 0, 0, 32'h9, 4'b0001, 1, 4'h0, 2, 0, 0, '0, 0, '0));
        tbl.push_back(mk(1, 0, 0, 32'hA, 4'b0010, 2, 4'h0, 3, 0, 0, '0, 0, '0));
        tbl.push_back(mk(1, 1, 0, 32'hB, 4'b0100, 3, 4'hF, 0, 1,
                         0, '0, 1, {32'hB, 32'hA, 32'h9, 32'h8}));

        foreach (tbl[i]) begin
            t = tbl[i];
            drive(t.v, t.f, t.r, t.d);
            chk("tbl_vout0", 0, 256'(a_vout[0]), 256'(t.ev0));
            chk("tbl_ptr0", 0, 256'(a_ptr[0]), 256'(t.ep0));
            chk("tbl_vout1", 1, 256'(a_vout[1]), 256'(t.ev1));
            chk("tbl_ptr1", 1, 256'(a_ptr[1]), 256'(t.ep1));
            chk("tbl_gd1", 1, 256'(a_gd[1]), 256'(t.egd1));
            if (t.cl0) chk("tbl_lanes0", 0, a_lane[0], 256'(t.el0));
            if (t.cl1) chk("tbl_lanes1", 1, a_lane[1], 256'(t.el1));
        end

        // ---- 8-lane resync mid-group, then a clean group ----
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'hC1 + 32'(i));
        drive(1'b1, 1'b0, 1'b1, 32'hC4);
        chk("rs8_vout", 2, 256'(a_vout[2]), 256'(0));
        chk("rs8_ptr", 2, 256'(a_ptr[2]), 256'(0));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'hD0 + 32'(i));
            if (i < 7) chk("rs8_quiet", 2, 256'(a_vout[2]), 256'(0));
        end
        chk("rs8_gd", 2, 256'(a_gd[2]), 256'(1));
        chk("rs8_vall", 2, 256'(a_vout[2]), 256'(8'hFF));
        chk("rs8_lane0", 2, 256'(a_lane[2][31:0]), 256'(32'hD0));

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0, $urandom);
        end

        // ---- asynchronous reset mid-group ----
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'hF1);
        drive(1'b1, 1'b0, 1'b0, 32'hF2);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        snap();
        for (int d = 0; d < 3; d++) begin
            chk("arst_lane", d, a_lane[d], 256'(0));
            chk("arst_vout", d, 256'(a_vout[d]), 256'(0));
            chk("arst_ptr", d, 256'(a_ptr[d]), 256'(0));
            chk("arst_gd", d, 256'(a_gd[d]), 256'(0));
        end
        @(posedge clk_2f);
        #1;
        reset = 1'b0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            w = 32'hE0 + 32'(i);
            drive(1'b1, 1'b0, 1'b0, w);
            if (i == 0) begin
                chk("post_rst_lane0", 0, 256'(a_lane[0][31:0]), 256'(32'hE0));
                chk("post_rst_vout0", 0, 256'(a_vout[0]), 256'(1));
            end
        end
        chk("post_rst_gd1", 1, 256'(a_gd[1]), 256'(1));
        chk("post_rst_grp1", 1, 256'(a_lane[1][127:0]), 256'({32'hE3, 32'hE2, 32'hE1, 32'hE0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
